// File: rtl/pe_pkg.sv
// Shared constants for the PE array sequencer: per-PE mode codes, job opcodes and
// the controller state encoding.
package pe_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SA     = 2'd1;
  localparam logic [1:0] MODE_SAVE   = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic OP_SA     = 1'b0;
  localparam logic OP_SINGLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/pe_mode_align.sv
// One-cycle register stage that delays per-PE mode and activate so they reach the
// PEs together with the buffer data read at the paired address.
module pe_mode_align
  import pe_pkg::*;
#(
  parameter int NUM_PE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*NUM_PE-1:0]   mode_i,
  input  logic                  act_i,
  output logic [2*NUM_PE-1:0]   mode_o,
  output logic                  act_o
);

  logic [2*NUM_PE-1:0] mode_q;
  logic                act_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= {NUM_PE{MODE_HOLD}};
      act_q  <= 1'b0;
    end else begin
      mode_q <= mode_i;
      act_q  <= act_i;
    end
  end

  assign mode_o = mode_q;
  assign act_o  = act_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for a 1-D PE chain: runs SA jobs (load weights, stream inputs, drain)
// and SINGLE jobs (accumulate in PE0), issuing buffer addresses and per-PE modes.
// Handshake: start_i is taken only in IDLE with abort_i low; busy_o stays high while
// a job is in flight and done_o pulses for one cycle in the job's final cycle.
module pe_array_ctrl
  import pe_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int LEN_W  = 5,
  parameter int AW     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                cfg_op_i,
  input  logic [LEN_W-1:0]    cfg_len_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [AW-1:0]       wbuf_addr_o,
  output logic [AW-1:0]       ibuf_addr_o,
  output logic [2*NUM_PE-1:0] pe_mode_o,
  output logic                pe_activate_o,
  output ctrl_state_e         dbg_state_o
);

  // cnt must reach NUM_PE in SA drain and cfg_len-1 in RUN
  localparam int CW = (LEN_W > $clog2(NUM_PE + 1)) ? LEN_W : $clog2(NUM_PE + 1);

  ctrl_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                op_q, op_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2*NUM_PE-1:0] mode_raw;
  logic                act_raw;
  logic                load_last, run_last, drain_last;

  assign load_last  = (cnt_q == CW'(NUM_PE - 1));
  assign run_last   = (cnt_q == CW'(len_q) - CW'(1));
  assign drain_last = (op_q == OP_SINGLE) ? (cnt_q == '0) : (cnt_q == CW'(NUM_PE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_SA;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    wbuf_addr_o = '0;
    ibuf_addr_o = '0;
    mode_raw    = {NUM_PE{MODE_HOLD}};
    act_raw     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          op_d  = cfg_op_i;
          len_d = cfg_len_i;
          if (cfg_op_i == OP_SINGLE) state_d = (cfg_len_i == '0) ? ST_DRAIN : ST_RUN;
          else                       state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wbuf_addr_o = AW'(cnt_q);
        for (int k = 0; k < NUM_PE; k++) begin
          if (cnt_q == CW'(k)) mode_raw[2*k +: 2] = MODE_SAVE;
        end
        if (load_last) state_d = (len_q == '0) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        ibuf_addr_o = AW'(cnt_q);
        act_raw     = 1'b1;
        if (op_q == OP_SINGLE) begin
          wbuf_addr_o   = AW'(cnt_q);
          mode_raw[1:0] = MODE_SINGLE;
        end else begin
          mode_raw = {NUM_PE{MODE_SA}};
        end
        if (run_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (op_q == OP_SINGLE) mode_raw[1:0] = MODE_SINGLE;
        else                   mode_raw      = {NUM_PE{MODE_SA}};
        if (drain_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any normal transition and parks the chain in HOLD next cycle
    if (abort_i && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      mode_raw = {NUM_PE{MODE_HOLD}};
      act_raw  = 1'b0;
    end

    cnt_d = (state_d == state_q && state_q != ST_IDLE) ? cnt_q + CW'(1) : '0;
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE) && !abort_i;
  assign dbg_state_o = state_q;

  pe_mode_align #(
    .NUM_PE (NUM_PE)
  ) u_align (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode_raw),
    .act_i  (act_raw),
    .mode_o (pe_mode_o),
    .act_o  (pe_activate_o)
  );

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: a job-timeline model predicts every output each cycle,
// and directed jobs add literal spot checks at hand-computed cycles.
module tb_pe_array_ctrl;
  import pe_pkg::*;

  localparam int N     = 4;
  localparam int LEN_W = 5;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cfg_op = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              abort = 1'b0;
  logic              busy, done, act;
  logic [AW-1:0]     wbuf, ibuf;
  logic [2*N-1:0]    pe_mode;
  ctrl_state_e       dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Current job as seen by the model: accept cycle, op, length, abort cycle
  int   t0      = -1000;
  logic m_op    = 1'b0;
  int   m_len   = 0;
  int   m_abort = 1 << 30;
  bit   chk_en  = 1'b0;

  pe_array_ctrl #(.NUM_PE(N), .LEN_W(LEN_W), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .cfg_op_i      (cfg_op),
    .cfg_len_i     (cfg_len),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .wbuf_addr_o   (wbuf),
    .ibuf_addr_o   (ibuf),
    .pe_mode_o     (pe_mode),
    .pe_activate_o (act),
    .dbg_state_o   (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- model ----------------
  function automatic int m_done_t();
    return m_op ? m_len + 2 : 2*N + m_len + 2;
  endfunction

  function automatic int m_wbuf(input int r);
    if (r > m_abort) return 0;
    if (!m_op && r >= 1 && r <= N) return r - 1;
    if (m_op && r >= 1 && r <= m_len) return r - 1;
    return 0;
  endfunction

  function automatic int m_ibuf(input int r);
    int rs;
    rs = m_op ? 1 : N + 1;
    if (r > m_abort) return 0;
    if (r >= rs && r < rs + m_len) return r - rs;
    return 0;
  endfunction

  // What the chain must be told in relative cycle x (seen at the PEs in cycle x+1)
  function automatic void m_raw(input int x, output logic [2*N-1:0] m, output logic a);
    for (int k = 0; k < N; k++) m[2*k +: 2] = MODE_HOLD;
    a = 1'b0;
    if (x < 1 || x >= m_abort || x >= m_done_t()) return;
    if (!m_op) begin
      if (x <= N) m[2*(x-1) +: 2] = MODE_SAVE;
      else for (int k = 0; k < N; k++) m[2*k +: 2] = MODE_SA;
      a = (x > N) && (x <= N + m_len);
    end else begin
      m[1:0] = MODE_SINGLE;
      a = (x <= m_len);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int r;
      logic [2*N-1:0] em;
      logic ea;
      r = cyc - t0;
      m_raw(r - 1, em, ea);
      chk("busy", busy, (r >= 1 && r <= m_done_t() && r <= m_abort));
      chk("done", done, (r == m_done_t() && r <= m_abort));
      chk("wbuf", wbuf, m_wbuf(r));
      chk("ibuf", ibuf, m_ibuf(r));
      chk("pe_mode", pe_mode, em);
      chk("activate", act, ea);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic op, input int len);
    cfg_op  = op;
    cfg_len = LEN_W'(len);
    start   = 1'b1;
    m_op    = op;
    m_len   = len;
    m_abort = 1 << 30;
    t0      = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_r(input int r);
    while (cyc - t0 < r) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst    = 1'b0;
    t0     = -1000;
    chk_en = 1'b1;

    // Reset/idle values
    repeat (5) tick();
    chk("rst_mode", pe_mode, 8'hFF);
    chk("rst_act", act, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);

    // SA job, L=3
    start_job(OP_SA, 3);
    wait_r(1);  chk("sa_wbuf0", wbuf, 5'd0);
    wait_r(2);  chk("sa_mode2", pe_mode, 8'hFE);
    wait_r(3);  chk("sa_mode3", pe_mode, 8'hFB);
    wait_r(4);  chk("sa_mode4", pe_mode, 8'hEF); chk("sa_wbuf3", wbuf, 5'd3);
    wait_r(5);  chk("sa_mode5", pe_mode, 8'hBF); chk("sa_ibuf0", ibuf, 5'd0);
    wait_r(6);  chk("sa_act6", act, 1'b1);
    wait_r(7);  chk("sa_ibuf2", ibuf, 5'd2);
    wait_r(9);  chk("sa_act9", act, 1'b0); chk("sa_mode9", pe_mode, 8'h55);
    wait_r(13); chk("sa_done13", done, 1'b1);
    wait_r(14); chk("sa_busy14", busy, 1'b0);
    wait_r(16);

    // SINGLE job, L=5
    start_job(OP_SINGLE, 5);
    wait_r(1); chk("sg_wbuf0", wbuf, 5'd0); chk("sg_ibuf0", ibuf, 5'd0);
    wait_r(2); chk("sg_mode2", pe_mode, 8'hFC);
    wait_r(5); chk("sg_wbuf4", wbuf, 5'd4); chk("sg_ibuf4", ibuf, 5'd4);
    wait_r(7); chk("sg_done7", done, 1'b1);
    wait_r(8); chk("sg_busy8", busy, 1'b0);
    wait_r(10);

    // SA job, L=0: LOAD then DRAIN
    start_job(OP_SA, 0);
    wait_r(6);  chk("l0_mode6", pe_mode, 8'h55); chk("l0_act6", act, 1'b0);
    wait_r(10); chk("l0_done10", done, 1'b1);
    wait_r(12);

    // Abort in the second RUN cycle, restart right after
    start_job(OP_SA, 4);
    wait_r(6);
    abort   = 1'b1;
    m_abort = 6;
    tick();
    abort   = 1'b0;
    chk("ab_busy", busy, 1'b0);
    chk("ab_mode", pe_mode, 8'hFF);
    chk("ab_act", act, 1'b0);
    chk("ab_state", dbg_state, ST_IDLE);
    start_job(OP_SINGLE, 2);
    chk("ab_restart_busy", busy, 1'b1);
    wait_r(4); chk("ab_restart_done", done, 1'b1);
    wait_r(6);

    // start together with abort in IDLE is ignored
    cfg_op  = OP_SA;
    cfg_len = 5'd3;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    chk("sa_ab_idle_busy", busy, 1'b0);
    tick();
    chk("sa_ab_idle_state", dbg_state, ST_IDLE);

    // start while busy is ignored and does not alter the running job
    start_job(OP_SA, 2);
    wait_r(3);
    cfg_op  = OP_SINGLE;
    cfg_len = 5'd7;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_r(12); chk("bz_done12", done, 1'b1);
    wait_r(13);

    // Async reset in the middle of DRAIN
    start_job(OP_SA, 5);
    wait_r(11);
    chk("pre_rst_mode", pe_mode, 8'h55);
    chk_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_mode", pe_mode, 8'hFF);
    chk("arst_act", act, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_wbuf", wbuf, 5'd0);
    chk("arst_ibuf", ibuf, 5'd0);
    chk("arst_state", dbg_state, ST_IDLE);
    tick();
    rst    = 1'b0;
    t0     = -1000;
    chk_en = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
